// File: rtl/key_pkg.sv
// Shared types for the key event decoder: event codes, FSM states, timer width.
package key_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_SHORT  = 3'd1,
    EV_DOUBLE = 3'd2,
    EV_LONG   = 3'd3,
    EV_REPEAT = 3'd4
  } ev_code_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } key_state_t;

  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clk cycles.
module ms_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and pulse tick on the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Key event decoder: turns a debounced key level into SHORT / DOUBLE / LONG
// (and optionally REPEAT) events with a valid/ready output and a sticky
// overflow flag. Define KEY_EVENT_REPEAT_EN to enable auto-repeat in HELD.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int LONG_MS   = 800,
  parameter int DCLICK_MS = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_db,
  output logic [2:0] ev_code,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_ovf,
  input  logic       ovf_clr
);

  localparam logic [TIMER_W-1:0] LONG_T   = TIMER_W'(LONG_MS);
  localparam logic [TIMER_W-1:0] DCLICK_T = TIMER_W'(DCLICK_MS);

  logic               tick;
  logic               key_q;
  logic               rise, fall;
  logic [TIMER_W-1:0] timer;
  key_state_t         state, nxt_state;
  ev_code_t           new_ev;
  logic               emit, tmr_clr, drop;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign rise = key_db & ~key_q;
  assign fall = ~key_db & key_q;
  assign drop = emit & ev_valid & ~ev_ready;

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [TIMER_W-1:0] REPEAT_T = TIMER_W'(REPEAT_MS);
`else
  // REPEAT_MS only shapes the repeat build; referenced here so it stays elaborated.
  if (REPEAT_MS < 0) begin : g_repeat_ms_unused
  end
`endif

  // Next-state / event decision; key edges always win over timer expiry.
  always_comb begin
    nxt_state = state;
    new_ev    = EV_NONE;
    emit      = 1'b0;
    tmr_clr   = 1'b0;
    case (state)
      ST_IDLE: if (rise) nxt_state = ST_PRESS1;
      ST_PRESS1: begin
        if (fall) nxt_state = ST_GAP;
        else if (timer == LONG_T) begin
          new_ev = EV_LONG; emit = 1'b1; nxt_state = ST_HELD;
        end
      end
      ST_GAP: begin
        if (rise) nxt_state = ST_PRESS2;
        else if (timer == DCLICK_T) begin
          new_ev = EV_SHORT; emit = 1'b1; nxt_state = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        // A second press that turns into a hold still reports DOUBLE, never LONG.
        if (fall) begin
          new_ev = EV_DOUBLE; emit = 1'b1; nxt_state = ST_IDLE;
        end else if (timer == LONG_T) begin
          new_ev = EV_DOUBLE; emit = 1'b1; nxt_state = ST_HELD;
        end
      end
      ST_HELD: begin
        if (fall) nxt_state = ST_IDLE;
`ifdef KEY_EVENT_REPEAT_EN
        else if (timer == REPEAT_T) begin
          new_ev = EV_REPEAT; emit = 1'b1; tmr_clr = 1'b1;
        end
`endif
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // FSM state, tick timer, and the registered event/overflow outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      timer    <= '0;
      key_q    <= 1'b0;
      ev_valid <= 1'b0;
      ev_code  <= 3'd0;
      ev_ovf   <= 1'b0;
    end else begin
      key_q <= key_db;
      state <= nxt_state;
      if (nxt_state != state || tmr_clr) timer <= '0;
      else if (tick && timer != TIMER_MAX) timer <= timer + 1'b1;

      // A pending unconsumed event is never overwritten; the newcomer is dropped.
      if (emit && !drop) begin
        ev_valid <= 1'b1;
        ev_code  <= new_ev;
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end

      if (drop) ev_ovf <= 1'b1;
      else if (ovf_clr) ev_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with a fast tick (10 clk per ms).
module tb_key_event_decoder;

  logic       clk = 1'b0;
  logic       reset, key_db, ev_ready, ovf_clr;
  logic [2:0] ev_code;
  logic       ev_valid, ev_ovf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ev_c[$];
  int ev_t[$];

  key_event_decoder #(
    .TICK_DIV(10), .LONG_MS(50), .DCLICK_MS(20), .REPEAT_MS(10)
  ) dut (
    .clk(clk), .reset(reset), .key_db(key_db), .ev_code(ev_code),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ovf(ev_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Log every accepted event with the cycle it was taken.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && ev_valid && ev_ready) begin
      ev_c.push_back(int'(ev_code));
      ev_t.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; key_db = 1'b0; ev_ready = 1'b1; ovf_clr = 1'b0;
    idle(3);
    vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0d expected 0", ev_valid); end
    vectors++; if (ev_code !== 3'd0) begin miscompares++; $display("FAIL rst_code: got %0d expected 0", ev_code); end
    vectors++; if (ev_ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %0d expected 0", ev_ovf); end
    reset = 1'b0;
    idle(5);
    vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_valid: got %0d expected 0", ev_valid); end
  endtask

  task automatic test_short;
    int t_rel, code, dt;
    ev_c.delete(); ev_t.delete();
    key_db = 1'b1; idle(100);
    key_db = 1'b0; t_rel = cyc; idle(300);
    code = (ev_c.size() > 0) ? ev_c[0] : -1;
    dt   = (ev_t.size() > 0) ? ev_t[0] - t_rel : -1;
    vectors++; if (ev_c.size() !== 1) begin miscompares++; $display("FAIL short_count: got %0d expected 1", ev_c.size()); end
    vectors++; if (code !== 1) begin miscompares++; $display("FAIL short_code: got %0d expected 1", code); end
    vectors++; if (!(dt >= 185 && dt <= 215)) begin miscompares++; $display("FAIL short_delay: got %0d expected 185..215", dt); end
  endtask

  task automatic test_double;
    ev_c.delete(); ev_t.delete();
    key_db = 1'b1; idle(100);
    key_db = 1'b0; idle(100);
    key_db = 1'b1; idle(100);
    vectors++; if (ev_c.size() !== 0) begin miscompares++; $display("FAIL dbl_early: got %0d events expected 0", ev_c.size()); end
    key_db = 1'b0;
    @(posedge clk); #1;
    vectors++; if (ev_valid !== 1'b1) begin miscompares++; $display("FAIL dbl_valid: got %0d expected 1", ev_valid); end
    vectors++; if (ev_code !== 3'd2) begin miscompares++; $display("FAIL dbl_code: got %0d expected 2", ev_code); end
    idle(300);
    vectors++; if (ev_c.size() !== 1) begin miscompares++; $display("FAIL dbl_count: got %0d expected 1", ev_c.size()); end
  endtask

  task automatic test_long;
    int t_r, dt;
`ifdef KEY_EVENT_REPEAT_EN
    int exp_c[4] = '{3, 4, 4, 4};
`else
    int exp_c[1] = '{3};
`endif
    ev_c.delete(); ev_t.delete();
    key_db = 1'b1; t_r = cyc; idle(810);
    key_db = 1'b0; idle(300);
    vectors++; if (ev_c.size() !== $size(exp_c)) begin miscompares++; $display("FAIL long_count: got %0d expected %0d", ev_c.size(), $size(exp_c)); end
    for (int i = 0; i < $size(exp_c); i++) begin
      int got = (i < ev_c.size()) ? ev_c[i] : -1;
      vectors++; if (got !== exp_c[i]) begin miscompares++; $display("FAIL long_code[%0d]: got %0d expected %0d", i, got, exp_c[i]); end
    end
    dt = (ev_t.size() > 0) ? ev_t[0] - t_r : -1;
    vectors++; if (!(dt >= 485 && dt <= 515)) begin miscompares++; $display("FAIL long_delay: got %0d expected 485..515", dt); end
`ifdef KEY_EVENT_REPEAT_EN
    for (int i = 1; i < 4; i++) begin
      dt = (i < ev_t.size()) ? ev_t[i] - ev_t[i-1] : -1;
      vectors++; if (!(dt >= 95 && dt <= 105)) begin miscompares++; $display("FAIL repeat_period[%0d]: got %0d expected 95..105", i, dt); end
    end
`endif
  endtask

  task automatic test_backpressure;
    ev_ready = 1'b0;
    key_db = 1'b1; idle(100); key_db = 1'b0; idle(300);
    vectors++; if (ev_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %0d expected 1", ev_valid); end
    vectors++; if (ev_code !== 3'd1) begin miscompares++; $display("FAIL bp_code: got %0d expected 1", ev_code); end
    vectors++; if (ev_ovf !== 1'b0) begin miscompares++; $display("FAIL bp_ovf_pre: got %0d expected 0", ev_ovf); end
    // DOUBLE is dropped in the same cycle ovf_clr is asserted: set must win.
    key_db = 1'b1; idle(100); key_db = 1'b0; idle(100); key_db = 1'b1; idle(100);
    key_db = 1'b0; ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    vectors++; if (ev_ovf !== 1'b1) begin miscompares++; $display("FAIL bp_ovf_set: got %0d expected 1", ev_ovf); end
    vectors++; if (ev_code !== 3'd1) begin miscompares++; $display("FAIL bp_code_kept: got %0d expected 1", ev_code); end
    idle(5);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    vectors++; if (ev_ovf !== 1'b0) begin miscompares++; $display("FAIL bp_ovf_clr: got %0d expected 0", ev_ovf); end
    vectors++; if (ev_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_held: got %0d expected 1", ev_valid); end
  endtask

  task automatic test_back_to_back;
    ev_c.delete(); ev_t.delete();
    // SHORT still pending; DOUBLE lands in the same cycle the SHORT is accepted.
    key_db = 1'b1; idle(100); key_db = 1'b0; idle(100); key_db = 1'b1; idle(100);
    key_db = 1'b0; ev_ready = 1'b1; idle(1);
    vectors++; if (ev_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %0d expected 1", ev_valid); end
    vectors++; if (ev_code !== 3'd2) begin miscompares++; $display("FAIL b2b_code: got %0d expected 2", ev_code); end
    vectors++; if (ev_ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf: got %0d expected 0", ev_ovf); end
    idle(1);
    vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %0d expected 0", ev_valid); end
    vectors++; if (ev_c.size() !== 2 || ev_c[0] !== 1 || ev_c[1] !== 2) begin
      miscompares++; $display("FAIL b2b_seq: got %0d events expected 2 (codes 1,2)", ev_c.size());
    end
    idle(300);
  endtask

  task automatic test_reset_mid_press;
    int t_r, code, dt;
    ev_ready = 1'b0;
    key_db = 1'b1; idle(100); key_db = 1'b0; idle(300);
    key_db = 1'b1; idle(100); key_db = 1'b0; idle(100); key_db = 1'b1; idle(100);
    key_db = 1'b0; idle(5);
    vectors++; if (ev_ovf !== 1'b1) begin miscompares++; $display("FAIL mid_ovf_pre: got %0d expected 1", ev_ovf); end
    key_db = 1'b1; idle(30);
    reset = 1'b1; idle(2);
    vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %0d expected 0", ev_valid); end
    vectors++; if (ev_code !== 3'd0) begin miscompares++; $display("FAIL mid_rst_code: got %0d expected 0", ev_code); end
    vectors++; if (ev_ovf !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ovf: got %0d expected 0", ev_ovf); end
    ev_c.delete(); ev_t.delete();
    reset = 1'b0; ev_ready = 1'b1; t_r = cyc;
    idle(520);
    key_db = 1'b0; idle(50);
    code = (ev_c.size() > 0) ? ev_c[0] : -1;
    dt   = (ev_t.size() > 0) ? ev_t[0] - t_r : -1;
    vectors++; if (ev_c.size() !== 1) begin miscompares++; $display("FAIL mid_count: got %0d expected 1", ev_c.size()); end
    vectors++; if (code !== 3) begin miscompares++; $display("FAIL mid_code: got %0d expected 3", code); end
    vectors++; if (!(dt >= 485 && dt <= 515)) begin miscompares++; $display("FAIL mid_delay: got %0d expected 485..515", dt); end
  endtask

  initial begin
    test_reset;
    test_short;
    test_double;
    test_long;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_press;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
